// File: rtl/clk_divider.sv
// Programmable core-clock generator: divides clk by 2*divider and either emits a
// fixed burst of rising edges (single/N-step) or runs free until reconfigured.
module clk_divider #(
  parameter int COUNTER_BITS = 32,
  parameter int PULSE_BITS   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_pulse,
  input  logic                    option,
  input  logic                    out_enable,
  input  logic [COUNTER_BITS-1:0] divider,
  input  logic [PULSE_BITS-1:0]   pulse,
  output logic                    clk_o,
  output logic                    busy,
  output logic [PULSE_BITS-1:0]   pulses_left
);

  typedef enum logic {
    MODE_BURST = 1'b0,
    MODE_AUTO  = 1'b1
  } mode_t;

  localparam logic [COUNTER_BITS-1:0] CNT_ONE   = COUNTER_BITS'(1);
  localparam logic [COUNTER_BITS-1:0] CNT_ZERO  = '0;
  localparam logic [PULSE_BITS-1:0]   PULS_ONE  = PULSE_BITS'(1);
  localparam logic [PULSE_BITS-1:0]   PULS_ZERO = '0;

  mode_t                   mode_reg, mode_next;
  logic [COUNTER_BITS-1:0] div_reg, div_next;
  logic [COUNTER_BITS-1:0] counter_reg, counter_next;
  logic [PULSE_BITS-1:0]   remaining_reg, remaining_next;
  logic                    clk_q_reg, clk_q_next;
  logic                    running;
  logic                    terminal;
  logic                    advance;

  // A burst keeps running until its final high phase has fully completed.
  assign running  = (mode_reg == MODE_AUTO) || (remaining_reg != PULS_ZERO) || clk_q_reg;
  assign terminal = (counter_reg == (div_reg - CNT_ONE));
  assign advance  = out_enable && running;

  always_comb begin
    mode_next      = mode_reg;
    div_next       = div_reg;
    counter_next   = counter_reg;
    remaining_next = remaining_reg;
    clk_q_next     = clk_q_reg;

    if (write_pulse) begin
      // Load wins over pause and over any run in progress, even mid-high-phase.
      mode_next      = mode_t'(option);
      div_next       = (divider == CNT_ZERO) ? CNT_ONE : divider;
      remaining_next = option ? PULS_ZERO : pulse;
      counter_next   = CNT_ZERO;
      clk_q_next     = 1'b0;
    end else if (advance) begin
      if (terminal) begin
        counter_next = CNT_ZERO;
        clk_q_next   = ~clk_q_reg;
        if (!clk_q_reg && (remaining_reg != PULS_ZERO)) begin
          remaining_next = remaining_reg - PULS_ONE;
        end
      end else begin
        counter_next = counter_reg + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg      <= MODE_BURST;
      div_reg       <= CNT_ONE;
      counter_reg   <= CNT_ZERO;
      remaining_reg <= PULS_ZERO;
      clk_q_reg     <= 1'b0;
    end else begin
      mode_reg      <= mode_next;
      div_reg       <= div_next;
      counter_reg   <= counter_next;
      remaining_reg <= remaining_next;
      clk_q_reg     <= clk_q_next;
    end
  end

  assign clk_o       = clk_q_reg;
  assign busy        = running;
  assign pulses_left = remaining_reg;

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider: reset, burst, auto, pause, reload and zero-burst scenarios.
module tb_clk_divider;

  logic        clk;
  logic        reset;
  logic        write_pulse;
  logic        option;
  logic        out_enable;
  logic [31:0] divider;
  logic [31:0] pulse;
  logic        clk_o;
  logic        busy;
  logic [31:0] pulses_left;

  int checks;
  int passes;

  clk_divider #(.COUNTER_BITS(32), .PULSE_BITS(32)) dut (
    .clk(clk),
    .reset(reset),
    .write_pulse(write_pulse),
    .option(option),
    .out_enable(out_enable),
    .divider(divider),
    .pulse(pulse),
    .clk_o(clk_o),
    .busy(busy),
    .pulses_left(pulses_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic opt, input logic [31:0] div, input logic [31:0] n);
    write_pulse = 1'b1;
    option      = opt;
    divider     = div;
    pulse       = n;
    tick();
    write_pulse = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({clk_o, busy, pulses_left} !== 34'd0) $display("FAIL reset_values got clk_o=%0b busy=%0b pulses_left=%0d want 0/0/0", clk_o, busy, pulses_left);
    else passes++;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({clk_o, busy, pulses_left} !== 34'd0) $display("FAIL idle_after_reset got clk_o=%0b busy=%0b pulses_left=%0d want 0/0/0", clk_o, busy, pulses_left);
    else passes++;
    $display("test_reset: power-up state checked");
  endtask

  task automatic test_burst();
    int rises;
    logic prev;
    logic exp_clk;
    int exp_pl;
    rises = 0;
    load(1'b0, 32'd3, 32'd4);
    prev = clk_o;
    checks++;
    if (clk_o !== 1'b0 || pulses_left !== 32'd4 || busy !== 1'b1) $display("FAIL burst_load got clk_o=%0b pl=%0d busy=%0b want 0/4/1", clk_o, pulses_left, busy);
    else passes++;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (!prev && clk_o) rises++;
      prev    = clk_o;
      exp_clk = (i < 24) && (((i / 3) % 2) == 1);
      exp_pl  = 4 - (((i / 3) + 1) / 2 > 4 ? 4 : ((i / 3) + 1) / 2);
      checks++;
      if (clk_o !== exp_clk || pulses_left !== 32'(exp_pl) || busy !== (i < 24))
        $display("FAIL burst_cycle%0d got clk_o=%0b pl=%0d busy=%0b want %0b/%0d/%0b", i, clk_o, pulses_left, busy, exp_clk, exp_pl, (i < 24));
      else passes++;
    end
    checks++;
    if (rises !== 4) $display("FAIL burst_rise_count got %0d want 4", rises);
    else passes++;
    $display("test_burst: divider=3 pulse=4 rises=%0d", rises);
  endtask

  task automatic test_reset_mid_burst();
    int highs;
    load(1'b0, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (clk_o !== 1'b1 || pulses_left !== 32'd3) $display("FAIL pre_reset_state got clk_o=%0b pl=%0d want 1/3", clk_o, pulses_left);
    else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({clk_o, busy, pulses_left} !== 34'd0) $display("FAIL async_reset got clk_o=%0b busy=%0b pl=%0d want 0/0/0", clk_o, busy, pulses_left);
    else passes++;
    tick();
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (clk_o || busy) highs++;
    end
    checks++;
    if (highs !== 0) $display("FAIL post_reset_quiet got %0d active cycles want 0", highs);
    else passes++;
    $display("test_reset_mid_burst: active cycles after release=%0d", highs);
  endtask

  task automatic test_auto();
    int errs;
    errs = 0;
    load(1'b1, 32'd0, 32'd7);
    checks++;
    if (clk_o !== 1'b0 || pulses_left !== 32'd0 || busy !== 1'b1) $display("FAIL auto_load got clk_o=%0b pl=%0d busy=%0b want 0/0/1", clk_o, pulses_left, busy);
    else passes++;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      checks++;
      if (clk_o !== 1'(i % 2) || busy !== 1'b1) begin
        errs++;
        $display("FAIL auto_cycle%0d got clk_o=%0b busy=%0b want %0b/1", i, clk_o, busy, 1'(i % 2));
      end else passes++;
    end
    load(1'b0, 32'd0, 32'd0);
    checks++;
    if (clk_o !== 1'b0 || busy !== 1'b0) $display("FAIL auto_stop got clk_o=%0b busy=%0b want 0/0", clk_o, busy);
    else passes++;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (clk_o !== 1'b0 || busy !== 1'b0) $display("FAIL auto_stopped got clk_o=%0b busy=%0b want 0/0", clk_o, busy);
    else passes++;
    $display("test_auto: 1000 cycles, errors=%0d", errs);
  endtask

  task automatic test_pause();
    int rises;
    int cycles;
    logic prev;
    load(1'b0, 32'd2, 32'd3);
    tick();
    tick();
    checks++;
    if (clk_o !== 1'b1 || pulses_left !== 32'd2) $display("FAIL pause_first_rise got clk_o=%0b pl=%0d want 1/2", clk_o, pulses_left);
    else passes++;
    out_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (clk_o !== 1'b1 || pulses_left !== 32'd2 || busy !== 1'b1)
        $display("FAIL pause_hold%0d got clk_o=%0b pl=%0d busy=%0b want 1/2/1", i, clk_o, pulses_left, busy);
      else passes++;
    end
    out_enable = 1'b1;
    rises  = 1;
    cycles = 0;
    prev   = clk_o;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      cycles++;
      if (!prev && clk_o) rises++;
      prev = clk_o;
    end
    checks++;
    if (rises !== 3) $display("FAIL pause_rise_count got %0d want 3", rises);
    else passes++;
    checks++;
    if (cycles !== 10) $display("FAIL pause_resume_len got %0d want 10", cycles);
    else passes++;
    $display("test_pause: rises=%0d resume_cycles=%0d", rises, cycles);
  endtask

  task automatic test_reload();
    int rises;
    logic prev;
    logic exp_clk;
    int exp_pl;
    load(1'b0, 32'd4, 32'd10);
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (clk_o !== 1'b1 || pulses_left !== 32'd8) $display("FAIL reload_second_rise got clk_o=%0b pl=%0d want 1/8", clk_o, pulses_left);
    else passes++;
    load(1'b0, 32'd1, 32'd2);
    checks++;
    if (clk_o !== 1'b0 || pulses_left !== 32'd2 || busy !== 1'b1) $display("FAIL reload_drop got clk_o=%0b pl=%0d busy=%0b want 0/2/1", clk_o, pulses_left, busy);
    else passes++;
    rises = 0;
    prev  = clk_o;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (!prev && clk_o) rises++;
      prev    = clk_o;
      exp_clk = (i < 4) && (i % 2 == 1);
      exp_pl  = (i >= 3) ? 0 : 1;
      checks++;
      if (clk_o !== exp_clk || pulses_left !== 32'(exp_pl) || busy !== (i < 4))
        $display("FAIL reload_cycle%0d got clk_o=%0b pl=%0d busy=%0b want %0b/%0d/%0b", i, clk_o, pulses_left, busy, exp_clk, exp_pl, (i < 4));
      else passes++;
    end
    checks++;
    if (rises !== 2) $display("FAIL reload_rise_count got %0d want 2", rises);
    else passes++;
    $display("test_reload: rises after reload=%0d", rises);
  endtask

  task automatic test_zero_burst();
    int active;
    active = 0;
    load(1'b0, 32'd5, 32'd0);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (clk_o || busy || pulses_left != 0) active++;
    end
    checks++;
    if (active !== 0) $display("FAIL zero_burst got %0d active cycles want 0", active);
    else passes++;
    $display("test_zero_burst: active cycles=%0d", active);
  endtask

  task automatic test_load_while_paused();
    out_enable = 1'b0;
    load(1'b0, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (clk_o !== 1'b0 || pulses_left !== 32'd1 || busy !== 1'b1) $display("FAIL paused_load got clk_o=%0b pl=%0d busy=%0b want 0/1/1", clk_o, pulses_left, busy);
    else passes++;
    out_enable = 1'b1;
    tick();
    checks++;
    if (clk_o !== 1'b1 || pulses_left !== 32'd0 || busy !== 1'b1) $display("FAIL paused_load_rise got clk_o=%0b pl=%0d busy=%0b want 1/0/1", clk_o, pulses_left, busy);
    else passes++;
    tick();
    checks++;
    if (clk_o !== 1'b0 || busy !== 1'b0) $display("FAIL paused_load_done got clk_o=%0b busy=%0b want 0/0", clk_o, busy);
    else passes++;
    $display("test_load_while_paused: single step completed");
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    reset       = 1'b1;
    write_pulse = 1'b0;
    option      = 1'b0;
    out_enable  = 1'b1;
    divider     = '0;
    pulse       = '0;
    test_reset();
    test_burst();
    test_reset_mid_burst();
    test_auto();
    test_pause();
    test_reload();
    test_zero_burst();
    test_load_while_paused();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
